reg_mem_wb_queue: RTL and testbench

//  Parametrised MEM->WB pipeline stage for the in-order core. Replaces the single-entry MEM/WB latch.

---
 rtl/reg_mem_wb_queue.sv | 192 +++++++++++++++++++
 tb/tb_reg_mem_wb_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_wb_queue.sv
// reg_mem_wb_queue
// MEM->WB pipeline stage built as a small circular buffer with valid/ready
// handshakes on both sides. It honours the global pipeline enable, turns a
// flush into a single bubble entry, and counts cycles in which the MEM side
// was held off by back-pressure. Outputs always come from registered storage.

module reg_mem_wb_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int EXP_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_pc,
  input  logic [31:0]                  in_ir,
  input  logic [DATA_W-1:0]            in_alu,
  input  logic [DATA_W-1:0]            in_mdr,
  input  logic [4:0]                   in_rd,
  input  logic                         in_dat2reg,
  input  logic                         in_regwrite,
  input  logic [EXP_W-1:0]             in_exp,
  input  logic                         in_illegal,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_ir,
  output logic [DATA_W-1:0]            out_alu,
  output logic [DATA_W-1:0]            out_mdr,
  output logic [4:0]                   out_rd,
  output logic                         out_dat2reg,
  output logic                         out_regwrite,
  output logic [EXP_W-1:0]             out_exp,
  output logic                         out_illegal,
  output logic                         out_flushed,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNT_W-1:0]             stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  // One buffered instruction; flushed marks a bubble created by a flush.
  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mdr;
    logic [4:0]        rd;
    logic              dat2reg;
    logic              regwrite;
    logic [EXP_W-1:0]  exp;
    logic              illegal;
    logic              flushed;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic   not_empty;
  logic   not_full;
  logic   in_ready_int;
  logic   out_valid_int;
  logic   push;
  logic   pop;
  logic   do_flush;
  logic   wr_en;
  entry_t wr_entry;
  entry_t head_entry;

  // Handshake decode: a full buffer can still accept when the head leaves in the same cycle.
  always_comb begin
    not_empty     = (count_q != '0);
    not_full      = (count_q < DEPTH_C);
    in_ready_int  = en & (not_full | (out_ready & not_empty));
    out_valid_int = en & not_empty;
    push          = in_valid & in_ready_int;
    pop           = out_valid_int & out_ready;
    do_flush      = en & flush;
  end

  // The stage never advertises readiness or validity while reset is held.
  assign in_ready  = rst_n & in_ready_int;
  assign out_valid = rst_n & out_valid_int;

  // Pointer, occupancy and storage update; a flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    wr_en    = 1'b0;
    wr_entry = '0;

    if (do_flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
      if (in_valid) begin
        wr_en            = 1'b1;
        wr_entry.pc      = in_pc;
        wr_entry.flushed = 1'b1;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        count_d          = OCC_W'(1);
      end
    end else begin
      if (push) begin
        wr_en             = 1'b1;
        wr_entry.pc       = in_pc;
        wr_entry.ir       = in_ir;
        wr_entry.alu      = in_alu;
        wr_entry.mdr      = in_mdr;
        wr_entry.rd       = in_rd;
        wr_entry.dat2reg  = in_dat2reg;
        wr_entry.regwrite = in_regwrite;
        wr_entry.exp      = in_exp;
        wr_entry.illegal  = in_illegal;
        wr_entry.flushed  = 1'b0;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end

    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_entry;
    end
  end

  // Back-pressure statistic: counts refused offers while enabled, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (en && in_valid && !in_ready_int && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Head read: an empty buffer presents all-zero fields to write-back.
  always_comb begin
    head_entry = '0;
    if (not_empty) begin
      head_entry = mem_q[rd_ptr_q];
    end
  end

  assign out_pc       = head_entry.pc;
  assign out_ir       = head_entry.ir;
  assign out_alu      = head_entry.alu;
  assign out_mdr      = head_entry.mdr;
  assign out_rd       = head_entry.rd;
  assign out_dat2reg  = head_entry.dat2reg;
  assign out_regwrite = head_entry.regwrite;
  assign out_exp      = head_entry.exp;
  assign out_illegal  = head_entry.illegal;
  assign out_flushed  = head_entry.flushed;
  assign count        = count_q;
  assign stall_cnt    = stall_cnt_q;

  // State registers; reset drops every in-flight entry and clears the storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      stall_cnt_q <= stall_cnt_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_reg_mem_wb_queue.sv
// tb_reg_mem_wb_queue
// Drives two instances of the MEM->WB queue from the same inputs: a 2-entry
// one with a 16-bit stall counter and a 4-entry one with a 4-bit stall counter.
// Each is compared every cycle against a queue-based reference model.

module tb_reg_mem_wb_queue;

  localparam int HEAD_W = 142;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ir;
  logic [31:0] in_alu;
  logic [31:0] in_mdr;
  logic [4:0]  in_rd;
  logic        in_dat2reg;
  logic        in_regwrite;
  logic [4:0]  in_exp;
  logic        in_illegal;

  logic        a_in_ready, a_out_valid, a_out_dat2reg, a_out_regwrite, a_out_illegal, a_out_flushed;
  logic [31:0] a_out_pc, a_out_ir, a_out_alu, a_out_mdr;
  logic [4:0]  a_out_rd, a_out_exp;
  logic [1:0]  a_count;
  logic [15:0] a_stall_cnt;

  logic        b_in_ready, b_out_valid, b_out_dat2reg, b_out_regwrite, b_out_illegal, b_out_flushed;
  logic [31:0] b_out_pc, b_out_ir, b_out_alu, b_out_mdr;
  logic [4:0]  b_out_rd, b_out_exp;
  logic [2:0]  b_count;
  logic [3:0]  b_stall_cnt;

  logic [HEAD_W-1:0] a_head, b_head;

  int checks;
  int errors;

  logic [HEAD_W-1:0] mq_a[$];
  logic [HEAD_W-1:0] mq_b[$];
  int                ms_a;
  int                ms_b;

  reg_mem_wb_queue #(.DATA_W(32), .DEPTH(2), .EXP_W(5), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_alu(in_alu), .in_mdr(in_mdr), .in_rd(in_rd),
    .in_dat2reg(in_dat2reg), .in_regwrite(in_regwrite), .in_exp(in_exp), .in_illegal(in_illegal),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_ir(a_out_ir), .out_alu(a_out_alu), .out_mdr(a_out_mdr), .out_rd(a_out_rd),
    .out_dat2reg(a_out_dat2reg), .out_regwrite(a_out_regwrite), .out_exp(a_out_exp),
    .out_illegal(a_out_illegal), .out_flushed(a_out_flushed),
    .count(a_count), .stall_cnt(a_stall_cnt)
  );

  reg_mem_wb_queue #(.DATA_W(32), .DEPTH(4), .EXP_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_alu(in_alu), .in_mdr(in_mdr), .in_rd(in_rd),
    .in_dat2reg(in_dat2reg), .in_regwrite(in_regwrite), .in_exp(in_exp), .in_illegal(in_illegal),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_ir(b_out_ir), .out_alu(b_out_alu), .out_mdr(b_out_mdr), .out_rd(b_out_rd),
    .out_dat2reg(b_out_dat2reg), .out_regwrite(b_out_regwrite), .out_exp(b_out_exp),
    .out_illegal(b_out_illegal), .out_flushed(b_out_flushed),
    .count(b_count), .stall_cnt(b_stall_cnt)
  );

  assign a_head = {a_out_pc, a_out_ir, a_out_alu, a_out_mdr, a_out_rd, a_out_dat2reg,
                   a_out_regwrite, a_out_exp, a_out_illegal, a_out_flushed};
  assign b_head = {b_out_pc, b_out_ir, b_out_alu, b_out_mdr, b_out_rd, b_out_dat2reg,
                   b_out_regwrite, b_out_exp, b_out_illegal, b_out_flushed};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports each mismatch
  task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: checks one instance against its queue, then advances the queue by one edge
  task automatic modelCheckAndStep(input int k);
    logic [HEAD_W-1:0] q[$];
    logic [HEAD_W-1:0] entry;
    logic [HEAD_W-1:0] exp_head;
    logic [HEAD_W-1:0] obs_head;
    int   depth;
    int   smax;
    int   stall;
    logic exp_ready;
    logic exp_valid;
    logic obs_ready;
    logic obs_valid;
    int   obs_count;
    int   obs_stall;
    string sfx;

    if (k == 0) begin
      q = mq_a; depth = 2; smax = 65535; stall = ms_a; sfx = "a";
      obs_ready = a_in_ready; obs_valid = a_out_valid; obs_head = a_head;
      obs_count = int'(a_count); obs_stall = int'(a_stall_cnt);
    end else begin
      q = mq_b; depth = 4; smax = 15; stall = ms_b; sfx = "b";
      obs_ready = b_in_ready; obs_valid = b_out_valid; obs_head = b_head;
      obs_count = int'(b_count); obs_stall = int'(b_stall_cnt);
    end

    exp_ready = en && ((q.size() < depth) || (out_ready && q.size() != 0));
    exp_valid = en && (q.size() != 0);
    exp_head  = (q.size() != 0) ? q[0] : '0;

    checkOutput({"in_ready_", sfx}, 160'(obs_ready), 160'(exp_ready));
    checkOutput({"out_valid_", sfx}, 160'(obs_valid), 160'(exp_valid));
    checkOutput({"head_", sfx}, 160'(obs_head), 160'(exp_head));
    checkOutput({"count_", sfx}, 160'(obs_count), 160'(q.size()));
    checkOutput({"stall_", sfx}, 160'(obs_stall), 160'(stall));

    if (en) begin
      if (in_valid && !exp_ready && stall < smax) stall++;
      if (flush) begin
        q.delete();
        if (in_valid) begin
          entry = '0;
          entry[HEAD_W-1 -: 32] = in_pc;
          entry[0] = 1'b1;
          q.push_back(entry);
        end
      end else begin
        if (exp_valid && out_ready) void'(q.pop_front());
        if (in_valid && exp_ready) begin
          q.push_back({in_pc, in_ir, in_alu, in_mdr, in_rd, in_dat2reg, in_regwrite,
                       in_exp, in_illegal, 1'b0});
        end
      end
    end

    if (k == 0) begin mq_a = q; ms_a = stall; end
    else begin mq_b = q; ms_b = stall; end
  endtask

  // One cycle of stimulus: drive on the falling edge, check just after, and let the model advance
  task automatic applyStimulus(input logic e, input logic f, input logic v, input logic r, input logic [31:0] pc);
    @(negedge clk);
    en          = e;
    flush       = f;
    in_valid    = v;
    out_ready   = r;
    in_pc       = pc;
    in_ir       = $urandom;
    in_alu      = $urandom;
    in_mdr      = $urandom;
    in_rd       = 5'($urandom);
    in_dat2reg  = 1'($urandom);
    in_regwrite = 1'($urandom);
    in_exp      = 5'($urandom);
    in_illegal  = 1'($urandom);
    #1;
    modelCheckAndStep(0);
    modelCheckAndStep(1);
  endtask

  // Asynchronous reset in the middle of a cycle with traffic offered; everything must read zero
  task automatic resetCheck();
    @(negedge clk);
    #2;
    en        = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkOutput("rst_in_ready_a", 160'(a_in_ready), 160'(0));
    checkOutput("rst_out_valid_a", 160'(a_out_valid), 160'(0));
    checkOutput("rst_head_a", 160'(a_head), 160'(0));
    checkOutput("rst_count_a", 160'(a_count), 160'(0));
    checkOutput("rst_stall_a", 160'(a_stall_cnt), 160'(0));
    checkOutput("rst_in_ready_b", 160'(b_in_ready), 160'(0));
    checkOutput("rst_head_b", 160'(b_head), 160'(0));
    checkOutput("rst_count_b", 160'(b_count), 160'(0));
    checkOutput("rst_stall_b", 160'(b_stall_cnt), 160'(0));
    mq_a.delete();
    mq_b.delete();
    ms_a = 0;
    ms_b = 0;
    en       = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    checks = 0;
    errors = 0;
    ms_a = 0;
    ms_b = 0;
    rst_n = 1'b0;
    en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_ir = '0; in_alu = '0; in_mdr = '0; in_rd = '0;
    in_dat2reg = 1'b0; in_regwrite = 1'b0; in_exp = '0; in_illegal = 1'b0;
    repeat (2) @(posedge clk);
    resetCheck();

    // Latency and ordering
    applyStimulus(1, 0, 1, 0, 32'h100);
    applyStimulus(1, 0, 1, 0, 32'h104);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("t2_count", 160'(a_count), 160'(2));
    checkOutput("t2_in_ready", 160'(a_in_ready), 160'(0));
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkOutput("t2_first", 160'(a_out_pc), 160'(32'h100));
    applyStimulus(1, 0, 0, 1, 32'h0);
    checkOutput("t2_second", 160'(a_out_pc), 160'(32'h104));

    // Full buffer with simultaneous push and pop
    applyStimulus(1, 0, 1, 0, 32'h110);
    applyStimulus(1, 0, 1, 0, 32'h114);
    applyStimulus(1, 0, 1, 1, 32'h118);
    checkOutput("t3_ready_full", 160'(a_in_ready), 160'(1));
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("t3_count", 160'(a_count), 160'(2));
    checkOutput("t3_head", 160'(a_out_pc), 160'(32'h114));

    // Flush with a bubble, then flush with nothing offered
    applyStimulus(1, 1, 1, 0, 32'h200);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("t4_count", 160'(a_count), 160'(1));
    checkOutput("t4_pc", 160'(a_out_pc), 160'(32'h200));
    checkOutput("t4_flushed", 160'(a_out_flushed), 160'(1));
    checkOutput("t4_ir", 160'(a_out_ir), 160'(0));
    checkOutput("t4_regwrite", 160'(a_out_regwrite), 160'(0));
    checkOutput("t4_exp", 160'(a_out_exp), 160'(0));
    applyStimulus(1, 1, 0, 1, 32'h0);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("t4_empty", 160'(a_count), 160'(0));

    // Freeze with en low, then back-pressure counting
    applyStimulus(1, 0, 1, 0, 32'h204);
    applyStimulus(1, 0, 1, 0, 32'h208);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 32'h300);
    applyStimulus(1, 0, 0, 0, 32'h0);
    checkOutput("t5_frozen", 160'(a_count), 160'(2));
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 32'h20c + 32'(i));

    // Pointer wrap with push/pop pairs, then stall-counter saturation
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'h400);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 1, 1, 32'h404 + 32'(4 * i));
    for (int i = 0; i < 24; i++) applyStimulus(1, 0, 1, 0, 32'h500 + 32'(i));
    checkOutput("t6_saturated", 160'(b_stall_cnt), 160'(15));

    // Mid-traffic reset
    resetCheck();
    applyStimulus(1, 0, 0, 0, 32'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) resetCheck();
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
